// File: rtl/fifo_pkg.sv
// Constants shared by the write-side and read-side FIFO controllers.
// Pointers carry one extra wrap bit beyond the memory address width.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 3;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int fifo_ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO: pointer, memory strobe,
// registered fill level, full/almost_full and sticky overflow.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int DEPTH      = fifo_depth(ADDR_WIDTH),
    parameter int AF_THRESH  = DEPTH - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rd_ptr_sync,
    input  logic                  ovf_clr,
    output logic [ADDR_WIDTH:0]   wr_ptr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow
);

    localparam int PW = fifo_ptr_width(ADDR_WIDTH);

    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] level_next;
    logic          full_next;
    logic          almost_full_next;
    logic          overflow_next;

    assign mem_we    = wr_en & ~full;
    assign mem_waddr = wr_ptr[ADDR_WIDTH-1:0];

    // Flags come from the post-write pointer so a filling write raises full
    // on its own edge; the stale read pointer only makes full pessimistic.
    always_comb begin
        wr_ptr_next      = wr_ptr + PW'(mem_we);
        level_next       = wr_ptr_next - rd_ptr_sync;
        full_next        = (level_next == PW'(DEPTH));
        almost_full_next = (level_next >= PW'(AF_THRESH));
        overflow_next    = overflow;
        if (wr_en && full) begin
            overflow_next = 1'b1;
        end else if (ovf_clr) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            level       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_next;
            level       <= level_next;
            full        <= full_next;
            almost_full <= almost_full_next;
            overflow    <= overflow_next;
        end
    end

endmodule
